// File: rtl/adder_seq.sv
// adder_seq: multi-cycle adder/subtractor that adds one SLICE-bit slice per
// clock, LSB slice first, behind valid/ready handshakes on both sides.
// SUM, CO and OV are registered and only meaningful while out_valid is high.
module adder_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] SUM,
  output logic             CO,
  output logic             OV
);

  localparam int N  = WIDTH / SLICE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic [IW-1:0]    idx;

  logic [SLICE-1:0] a_slice;
  logic [SLICE-1:0] b_slice;
  logic [SLICE:0]   slice_full;
  logic             msb_cin;

  // Add the current slice; the carry into the slice MSB is recovered from
  // its sum bit, so no separate SLICE-1 bit adder is needed (works for SLICE=1).
  always_comb begin
    a_slice    = a_reg[idx*SLICE +: SLICE];
    b_slice    = b_reg[idx*SLICE +: SLICE];
    slice_full = {1'b0, a_slice} + {1'b0, b_slice} + {{SLICE{1'b0}}, carry};
    msb_cin    = slice_full[SLICE-1] ^ a_slice[SLICE-1] ^ b_slice[SLICE-1];
  end

  // Control FSM plus datapath registers; handshake outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      SUM       <= '0;
      CO        <= 1'b0;
      OV        <= 1'b0;
      carry     <= 1'b0;
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= A;
            b_reg    <= B ^ {WIDTH{SUB}};
            carry    <= CI;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          SUM[idx*SLICE +: SLICE] <= slice_full[SLICE-1:0];
          carry <= slice_full[SLICE];
          idx   <= idx + IW'(1);
          if (idx == LAST_IDX) begin
            CO        <= slice_full[SLICE];
            OV        <= msb_cin ^ slice_full[SLICE];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
